// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache line <-> burst memory adaptor.
package cacheline_adaptor_pkg;

    localparam int CACHELINE_WIDTH = 256;
    localparam int BURST_WIDTH     = 64;
    localparam int BURST_BEATS     = CACHELINE_WIDTH / BURST_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } cla_state_t;

    // Extract beat number idx from a full cache line (beat 0 = least significant).
    function automatic logic [BURST_WIDTH-1:0] line_beat(
        input logic [CACHELINE_WIDTH-1:0] line,
        input logic [1:0]                 idx
    );
        return line[{idx, 6'b00_0000} +: BURST_WIDTH];
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts single 256-bit line reads/writes from the cache arbiter into
// 4-beat 64-bit bursts on the physical memory bus. All outputs are registered.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    cla_state_t             state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [31:0]            addr_q, addr_d;
    logic [LINE_WIDTH-1:0]  wline_q, wline_d;
    logic [LINE_WIDTH-1:0]  rline_q, rline_d;
    logic                   read_q, read_d;
    logic                   write_q, write_d;
    logic                   resp_q, resp_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;

    // Next-state logic: request capture, beat counting and output decode of the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;

        case (state_q)
            IDLE: begin
                // Read wins when both requests are raised together.
                if (read_i) begin
                    addr_d  = address_i & 32'hFFFF_FFE0;
                    state_d = RD;
                end else if (write_i) begin
                    addr_d  = address_i & 32'hFFFF_FFE0;
                    wline_d = line_i;
                    state_d = WR;
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (resp_i) begin
                    rline_d[{cnt_q, 6'b00_0000} +: BURST_WIDTH] = burst_i;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = 2'd0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            WR: begin
                if (resp_i) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = 2'd0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase

        // Outputs are precomputed from the next state so they leave flops directly.
        read_d  = (state_d == RD);
        write_d = (state_d == WR);
        resp_d  = (state_d == DONE);
        if (state_d == WR) begin
            burst_d = line_beat(wline_d, cnt_d);
        end else begin
            burst_d = {BURST_WIDTH{1'b0}};
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 32'd0;
            wline_q <= {LINE_WIDTH{1'b0}};
            rline_q <= {LINE_WIDTH{1'b0}};
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
            burst_q <= {BURST_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
            burst_q <= burst_d;
        end
    end

    assign line_o    = rline_q;
    assign resp_o    = resp_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign burst_o   = burst_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized self-checking bench for cacheline_adaptor against a transaction-level model.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    int total = 0;
    int bad   = 0;

    // Model state: the line the adaptor should currently present on line_o.
    logic [255:0] model_line;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic idle_cycles(input int n);
        read_i  = 1'b0;
        write_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            resp_i  = 1'($urandom_range(0, 1));
            burst_i = {$urandom, $urandom};
            tick();
            check_val("idle_resp_o", resp_o, 1'b0);
            check_val("idle_read_o", read_o, 1'b0);
            check_val("idle_write_o", write_o, 1'b0);
            check_val("idle_line_o", line_o, model_line);
        end
        resp_i = 1'b0;
    endtask

    // mode 0: beats back to back, mode 1: random stalls
    task automatic do_read(input logic [31:0] addr, input bit also_write, input int mode,
                           input bit perturb, input bit fixed_beats);
        logic [63:0]  beats [4];
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        int k;
        int cyc;
        exp_addr = {addr[31:5], 5'b00000};
        for (int i = 0; i < 4; i++) begin
            if (fixed_beats) beats[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
            else             beats[i] = {$urandom, $urandom};
            exp_line[i*64 +: 64] = beats[i];
        end
        address_i = addr;
        read_i    = 1'b1;
        write_i   = also_write;
        line_i    = rand_line();
        resp_i    = 1'b0;
        tick();
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 100) begin
            check_val("rd_read_o", read_o, 1'b1);
            check_val("rd_write_o", write_o, 1'b0);
            check_val("rd_resp_o", resp_o, 1'b0);
            check_val("rd_address_o", address_o, exp_addr);
            if (perturb && cyc == 1) begin
                address_i = 32'hFFFF_FFE0;
                line_i    = rand_line();
            end
            resp_i  = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            burst_i = resp_i ? beats[k] : {$urandom, $urandom};
            tick();
            if (resp_i) k++;
            cyc++;
        end
        check_val("rd_beats_done", k, 4);
        resp_i = 1'b0;
        check_val("rd_done_resp_o", resp_o, 1'b1);
        check_val("rd_done_read_o", read_o, 1'b0);
        check_val("rd_done_line_o", line_o, exp_line);
        model_line = exp_line;
        read_i  = 1'b0;
        write_i = 1'b0;
        tick();
        check_val("rd_after_resp_o", resp_o, 1'b0);
        check_val("rd_after_read_o", read_o, 1'b0);
        check_val("rd_after_line_o", line_o, model_line);
    endtask

    // mode 1: random stalls, mode 2: resp_i pattern 1,0,1,0,0,1,1
    task automatic do_write(input logic [31:0] addr, input int mode, input bit perturb);
        logic [255:0] wline;
        logic [31:0]  exp_addr;
        logic [6:0]   pat;
        int k;
        int cyc;
        pat      = 7'b110_0101;
        wline    = rand_line();
        exp_addr = {addr[31:5], 5'b00000};
        address_i = addr;
        read_i    = 1'b0;
        write_i   = 1'b1;
        line_i    = wline;
        resp_i    = 1'b0;
        tick();
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 100) begin
            check_val("wr_write_o", write_o, 1'b1);
            check_val("wr_read_o", read_o, 1'b0);
            check_val("wr_resp_o", resp_o, 1'b0);
            check_val("wr_address_o", address_o, exp_addr);
            check_val("wr_burst_o", burst_o, wline[k*64 +: 64]);
            if (perturb && cyc == 1) begin
                address_i = 32'hFFFF_FFE0;
                line_i    = rand_line();
            end
            if (mode == 2) resp_i = (cyc < 7) ? pat[cyc] : 1'b1;
            else           resp_i = 1'($urandom_range(0, 1));
            burst_i = {$urandom, $urandom};
            tick();
            if (resp_i) k++;
            cyc++;
        end
        check_val("wr_beats_done", k, 4);
        resp_i = 1'b0;
        check_val("wr_done_resp_o", resp_o, 1'b1);
        check_val("wr_done_write_o", write_o, 1'b0);
        check_val("wr_done_line_o", line_o, model_line);
        write_i = 1'b0;
        tick();
        check_val("wr_after_resp_o", resp_o, 1'b0);
        check_val("wr_after_write_o", write_o, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_resp_o"}, resp_o, 1'b0);
        check_val({tag, "_read_o"}, read_o, 1'b0);
        check_val({tag, "_write_o"}, write_o, 1'b0);
        check_val({tag, "_address_o"}, address_o, 32'd0);
        check_val({tag, "_burst_o"}, burst_o, 64'd0);
        check_val({tag, "_line_o"}, line_o, 256'd0);
    endtask

    // Main stimulus sequence.
    initial begin
        rst        = 1'b1;
        address_i  = 32'd0;
        read_i     = 1'b0;
        write_i    = 1'b0;
        line_i     = 256'd0;
        burst_i    = 64'd0;
        resp_i     = 1'b0;
        model_line = 256'd0;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");
        idle_cycles(3);

        // Directed read with known beats and unaligned address.
        do_read(32'h0000_1234, 1'b0, 0, 1'b0, 1'b1);
        check_val("rd_fixed_line", line_o,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        idle_cycles(2);

        // Write with the fixed stall pattern and perturbed inputs.
        do_write(32'h0000_8040, 2, 1'b1);
        idle_cycles(1);

        // Both requests at once: read must win.
        do_read(32'h1234_5678, 1'b1, 1, 1'b0, 1'b0);

        // Read with perturbed inputs mid-burst.
        do_read(32'hABCD_EF9F, 1'b0, 1, 1'b1, 1'b0);

        // Random mix of transactions.
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_read($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'b0);
            else
                do_write($urandom, 1, 1'($urandom_range(0, 1)));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        // Reset while idle.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_line = 256'd0;
        check_all_zero("idle_reset");

        // Reset mid-read after two beats, then a fresh read.
        address_i = 32'h0000_4000;
        read_i    = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            tick();
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        model_line = 256'd0;
        check_all_zero("midrd_reset");
        idle_cycles(2);
        do_read(32'h0000_4020, 1'b0, 1, 1'b0, 1'b0);
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
